multicycle_control_fsm: RTL and testbench

- Control unit for the multicycle ARM datapath, sitting directly upstream of the conditional-logic stage.
- Decodes the latched instruction fields and sequences each instruction through Fetch/Decode/Execute/Writeback states.
- Produces the raw, unconditioned PCS, NextPC, RegW, MemW and FlagW strobes. The conditional stage gates these with CondEx.
- Also drives datapath mux selects, IRWrite and ALUControl.

---
 rtl/multicycle_control_fsm.sv | 158 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM control unit: sequences each instruction through
// Fetch/Decode/Execute/Writeback and emits raw (unconditioned) strobes,
// datapath mux selects and ALU control.
// Optional feature: define UNDEF_TRAP_EN to make Op=11 trap into HALT
// (left only by reset); otherwise Op=11 is a no-op that sets Illegal.
module multicycle_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       Illegal
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, HALT
  } state_t;

  state_t state, state_next;
  logic   illegal_q;
  logic   ir_write, next_pc, reg_w, mem_w, branch, alu_op;

  // State register, asynchronously forced to FETCH by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= FETCH;
    else          state <= state_next;
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                          illegal_q <= 1'b0;
    else if (state == DECODE && Op == 2'b11) illegal_q <= 1'b1;
  end

  // Next-state sequencing.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = Funct[5] ? EXECI : EXECR;
          2'b10:   state_next = BRANCH;
`ifdef UNDEF_TRAP_EN
          default: state_next = HALT;
`else
          default: state_next = FETCH;
`endif
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
`ifdef UNDEF_TRAP_EN
      HALT:     state_next = HALT;
`endif
      default:  state_next = FETCH;
    endcase
  end

  // Moore outputs plus ALU decode; strobes are masked while reset is held
  // because the state register already sits in FETCH during reset.
  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    ResultSrc  = '0;
    ALUControl = '0;
    FlagW      = '0;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    case (state)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = 1'b1;
        next_pc   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR:    alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      HALT: begin
        ImmSrc = '0;
        RegSrc = '0;
      end
      default: ;
    endcase
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: ALUControl = 2'b00;
        4'b0010: ALUControl = 2'b01;
        4'b0000: ALUControl = 2'b10;
        4'b1100: ALUControl = 2'b11;
        default: ALUControl = 2'b00;
      endcase
      FlagW[1] = Funct[0];
      FlagW[0] = Funct[0] & ~ALUControl[1];
    end
    if (!RESET_N) FlagW = '0;
    IRWrite = ir_write & RESET_N;
    NextPC  = next_pc  & RESET_N;
    RegW    = reg_w    & RESET_N;
    MemW    = mem_w    & RESET_N;
    PCS     = (branch | ((Rd == 4'hF) & reg_w)) & RESET_N;
  end

  assign Illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a table of instructions
// whose per-instruction summaries go through a scoreboard queue, followed
// by hand-written sequences for reset, LDR-to-PC, branch and illegal ops.
module tb_multicycle_control_fsm;

  logic       CLK, RESET_N;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, NextPC, PCS, RegW, MemW, AdrSrc, Illegal;
  logic [1:0] FlagW, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .NextPC(NextPC), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .FlagW(FlagW), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .Illegal(Illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         cycles;
    logic [1:0] alu;
    logic [1:0] flagw;
    int         flag_cnt;
    int         regw_cnt;
    int         memw_cnt;
    int         pcs_cnt;
  } vec_t;

  typedef struct {
    int         cycles;
    logic [1:0] alu;
    logic [1:0] flagw;
    int         flag_cnt;
    int         regw_cnt;
    int         memw_cnt;
    int         pcs_cnt;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e, got;
    bit   done;

    //              op     funct       rd     cyc alu    flagw  fc rw mw pcs
    vecs[0] = '{2'b00, 6'b101001, 4'd3,  4, 2'b00, 2'b11, 1, 1, 0, 0}; // ADDS imm
    vecs[1] = '{2'b01, 6'b011001, 4'd15, 5, 2'b00, 2'b00, 0, 1, 0, 1}; // LDR pc
    vecs[2] = '{2'b01, 6'b011000, 4'd2,  4, 2'b00, 2'b00, 0, 0, 1, 0}; // STR
    vecs[3] = '{2'b10, 6'b100000, 4'd0,  3, 2'b00, 2'b00, 0, 0, 0, 1}; // B
    vecs[4] = '{2'b00, 6'b011000, 4'd4,  4, 2'b11, 2'b00, 0, 1, 0, 0}; // ORR
    vecs[5] = '{2'b00, 6'b000001, 4'd5,  4, 2'b10, 2'b10, 1, 1, 0, 0}; // ANDS
    vecs[6] = '{2'b00, 6'b000101, 4'd6,  4, 2'b01, 2'b11, 1, 1, 0, 0}; // SUBS
    vecs[7] = '{2'b00, 6'b000011, 4'd7,  4, 2'b00, 2'b11, 1, 1, 0, 0}; // cmd 0001
    vecs[8] = '{2'b00, 6'b001000, 4'd15, 4, 2'b00, 2'b00, 0, 1, 0, 1}; // ADD pc

    // Reset held: strobes forced low even though the state is FETCH.
    RESET_N = 1'b0; Op = '0; Funct = '0; Rd = '0;
    #1;
    check("rst_irwrite", IRWrite, 0);
    check("rst_nextpc", NextPC, 0);
    check("rst_illegal", Illegal, 0);
    tick; tick;
    check("rst_hold_irwrite", IRWrite, 0);
    check("rst_hold_alusrcb", ALUSrcB, 2);
    RESET_N = 1'b1;
    #1;
    check("rel_irwrite", IRWrite, 1);
    check("rel_nextpc", NextPC, 1);
    check("rel_alusrca", ALUSrcA, 1);
    check("rel_resultsrc", ResultSrc, 2);
    check("rel_adrsrc", AdrSrc, 0);
    check("rel_illegal", Illegal, 0);

    // Table-driven instructions, each starting in FETCH.
    for (int i = 0; i < 9; i++) begin
      Op = vecs[i].op; Funct = vecs[i].funct; Rd = vecs[i].rd;
      e.cycles   = vecs[i].cycles;   e.alu      = vecs[i].alu;
      e.flagw    = vecs[i].flagw;    e.flag_cnt = vecs[i].flag_cnt;
      e.regw_cnt = vecs[i].regw_cnt; e.memw_cnt = vecs[i].memw_cnt;
      e.pcs_cnt  = vecs[i].pcs_cnt;
      sb.push_back(e);
      got = '{1, 2'b00, 2'b00, 0, 0, 0, 0};
      done = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
        got.regw_cnt += int'(RegW);
        got.memw_cnt += int'(MemW);
        got.pcs_cnt  += int'(PCS);
        got.flag_cnt += int'(FlagW != 2'b00);
        got.flagw    |= FlagW;
        got.alu      |= ALUControl;
        tick;
        if (IRWrite) done = 1'b1;
        else got.cycles++;
      end
      check($sformatf("v%0d_completed", i), int'(done), 1);
      e = sb.pop_front();
      check($sformatf("v%0d_cycles", i), got.cycles, e.cycles);
      check($sformatf("v%0d_alucontrol", i), got.alu, e.alu);
      check($sformatf("v%0d_flagw", i), got.flagw, e.flagw);
      check($sformatf("v%0d_flagw_cycles", i), got.flag_cnt, e.flag_cnt);
      check($sformatf("v%0d_regw", i), got.regw_cnt, e.regw_cnt);
      check($sformatf("v%0d_memw", i), got.memw_cnt, e.memw_cnt);
      check($sformatf("v%0d_pcs", i), got.pcs_cnt, e.pcs_cnt);
      check($sformatf("v%0d_illegal", i), Illegal, 0);
    end

    // LDR to PC, state by state.
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd15;
    tick;
    check("ldr_dec_alusrca", ALUSrcA, 1);
    check("ldr_dec_alusrcb", ALUSrcB, 2);
    check("ldr_dec_irwrite", IRWrite, 0);
    tick;
    check("ldr_adr_alusrca", ALUSrcA, 0);
    check("ldr_adr_alusrcb", ALUSrcB, 1);
    tick;
    check("ldr_rd_adrsrc", AdrSrc, 1);
    check("ldr_rd_resultsrc", ResultSrc, 0);
    check("ldr_rd_regw", RegW, 0);
    tick;
    check("ldr_wb_resultsrc", ResultSrc, 1);
    check("ldr_wb_regw", RegW, 1);
    check("ldr_wb_pcs", PCS, 1);
    check("ldr_wb_regsrc", RegSrc, 2);
    check("ldr_wb_immsrc", ImmSrc, 1);
    tick;
    check("ldr_next_fetch", IRWrite, 1);

    // Reset asserted mid-MEMREAD.
    tick; tick; tick;
    check("mid_memread_adrsrc", AdrSrc, 1);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_irwrite", IRWrite, 0);
    check("mid_rst_regw", RegW, 0);
    check("mid_rst_pcs", PCS, 0);
    check("mid_rst_adrsrc", AdrSrc, 0);
    check("mid_rst_alusrcb", ALUSrcB, 2);
    tick;
    RESET_N = 1'b1;
    #1;
    check("mid_rel_irwrite", IRWrite, 1);
    check("mid_rel_nextpc", NextPC, 1);
    check("mid_rel_illegal", Illegal, 0);

    // Branch.
    Op = 2'b10; Funct = '0; Rd = '0;
    tick; tick;
    check("b_alusrca", ALUSrcA, 2);
    check("b_alusrcb", ALUSrcB, 1);
    check("b_resultsrc", ResultSrc, 2);
    check("b_pcs", PCS, 1);
    check("b_regw", RegW, 0);
    check("b_immsrc", ImmSrc, 2);
    check("b_regsrc", RegSrc, 1);
    tick;
    check("b_next_fetch", IRWrite, 1);

    // Illegal opcode.
    Op = 2'b11; Funct = 6'b000001; Rd = 4'd15;
    tick;
    check("ill_dec_illegal", Illegal, 0);
    check("ill_dec_regw", RegW, 0);
    tick;
    check("ill_after_illegal", Illegal, 1);
    check("ill_after_regw", RegW, 0);
    check("ill_after_memw", MemW, 0);
    check("ill_after_flagw", FlagW, 0);
`ifdef UNDEF_TRAP_EN
    check("halt_irwrite", IRWrite, 0);
    check("halt_nextpc", NextPC, 0);
    check("halt_alusrcb", ALUSrcB, 0);
    check("halt_immsrc", ImmSrc, 0);
    tick; tick; tick;
    check("halt_stay_irwrite", IRWrite, 0);
    check("halt_stay_pcs", PCS, 0);
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    #1;
    check("halt_exit_irwrite", IRWrite, 1);
    check("halt_exit_illegal", Illegal, 0);
`else
    check("ill_refetch", IRWrite, 1);
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
    tick; tick; tick;
    check("ill_follow_regw", RegW, 1);
    tick;
    check("ill_follow_fetch", IRWrite, 1);
    check("ill_sticky", Illegal, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
